// File: rtl/ariane_pkg.sv
// Shared core-wide constants and types used by the rename stage.
package ariane_pkg;

    localparam int unsigned NR_COMMIT_PORTS = 2;
    localparam int unsigned PHYS_REG_BITS   = 6;

    typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;

endpackage

// File: rtl/phys_free_list_pkg.sv
// Defaults and pointer helper for the physical register free list.
package phys_free_list_pkg;

    localparam int unsigned DEF_ARCH_REG_WIDTH = 5;
    localparam int unsigned DEF_PHYS_REG_WIDTH = $bits(ariane_pkg::phys_reg_t);
    localparam int unsigned DEF_NR_PORTS       = ariane_pkg::NR_COMMIT_PORTS;

    // Circular-buffer pointer advance; depth need not be a power of two.
    function automatic int unsigned wrap_ptr(input int unsigned base,
                                             input int unsigned inc,
                                             input int unsigned depth);
        return (base + inc) % depth;
    endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Allocation / release / status bundle between the renamer, commit and the free list.
interface phys_free_list_if
    import phys_free_list_pkg::*;
#(
    parameter int unsigned PHYS_REG_WIDTH = DEF_PHYS_REG_WIDTH,
    parameter int unsigned NR_PORTS       = DEF_NR_PORTS
);

    logic                                     alloc_req_i;
    logic                                     alloc_valid_o;
    logic [PHYS_REG_WIDTH-1:0]                alloc_preg_o;
    logic [NR_PORTS-1:0]                      release_valid_i;
    logic [NR_PORTS-1:0][PHYS_REG_WIDTH-1:0]  release_preg_i;
    logic [PHYS_REG_WIDTH-1:0]                free_count_o;
    logic                                     overflow_o;

    modport master (
        output alloc_req_i,
        output release_valid_i,
        output release_preg_i,
        input  alloc_valid_o,
        input  alloc_preg_o,
        input  free_count_o,
        input  overflow_o
    );

    modport slave (
        input  alloc_req_i,
        input  release_valid_i,
        input  release_preg_i,
        output alloc_valid_o,
        output alloc_preg_o,
        output free_count_o,
        output overflow_o
    );

endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical registers: one allocation per cycle from the head,
// up to NR_PORTS compacted releases per cycle at the tail.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int unsigned ARCH_REG_WIDTH = DEF_ARCH_REG_WIDTH,
    parameter int unsigned PHYS_REG_WIDTH = DEF_PHYS_REG_WIDTH,
    parameter int unsigned NR_PORTS       = DEF_NR_PORTS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    phys_free_list_if.slave    fl
);

    localparam int unsigned DEPTH = (1 << PHYS_REG_WIDTH) - (1 << ARCH_REG_WIDTH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PHYS_REG_WIDTH-1:0] preg_t;

    preg_t              buffer_q [DEPTH];
    preg_t              buffer_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               alloc_fire;

    // Room includes the slot freed by a same-cycle allocation, so a full list can
    // still take one release while it hands one out.
    always_comb begin
        int unsigned      room;
        int unsigned      accepted;
        logic [PTR_W-1:0] wr_idx;

        buffer_d   = buffer_q;
        overflow_d = overflow_q;
        wr_idx     = tail_q;
        accepted   = 0;

        alloc_fire = fl.alloc_req_i && (count_q != '0);
        room       = DEPTH - 32'(count_q) + 32'(alloc_fire);

        for (int p = 0; p < int'(NR_PORTS); p++) begin
            if (fl.release_valid_i[p] && (fl.release_preg_i[p] != '0)) begin
                if (accepted < room) begin
                    wr_idx           = PTR_W'(wrap_ptr(32'(tail_q), accepted, DEPTH));
                    buffer_d[wr_idx] = fl.release_preg_i[p];
                    accepted         = accepted + 1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end

        head_d  = alloc_fire ? PTR_W'(wrap_ptr(32'(head_q), 1, DEPTH)) : head_q;
        tail_d  = PTR_W'(wrap_ptr(32'(tail_q), accepted, DEPTH));
        count_d = CNT_W'(32'(count_q) + accepted - 32'(alloc_fire));
    end

    // Reset refills the list with every register above the architectural range.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buffer_q[i] <= PHYS_REG_WIDTH'((1 << ARCH_REG_WIDTH) + i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign fl.alloc_valid_o = (count_q != '0);
    assign fl.alloc_preg_o  = buffer_q[head_q];
    assign fl.free_count_o  = PHYS_REG_WIDTH'(count_q);
    assign fl.overflow_o    = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed-vector bench for phys_free_list: table rows plus hand-written wrap,
// overflow and reset sequences.
module tb_phys_free_list;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    phys_free_list_if #(.PHYS_REG_WIDTH(6), .NR_PORTS(2)) fl_if ();

    phys_free_list #(
        .ARCH_REG_WIDTH (5),
        .PHYS_REG_WIDTH (6),
        .NR_PORTS       (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fl    (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       alloc;
        logic [1:0] rel_valid;
        logic [5:0] rel_p0;
        logic [5:0] rel_p1;
        logic       exp_valid;
        logic       chk_preg;
        logic [5:0] exp_preg;
        logic [5:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [12];

    // Drives one cycle of inputs and returns 1 time unit after the clock edge.
    task automatic apply_stimulus(input logic alloc, input logic [1:0] rv,
                                  input logic [5:0] p0, input logic [5:0] p1);
        fl_if.alloc_req_i       = alloc;
        fl_if.release_valid_i   = rv;
        fl_if.release_preg_i[0] = p0;
        fl_if.release_preg_i[1] = p1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic ev, input logic cp,
                                input logic [5:0] ep, input logic [5:0] ec, input logic eo);
        logic bad;
        vectors++;
        bad = (fl_if.alloc_valid_o !== ev) || (fl_if.free_count_o !== ec) ||
              (fl_if.overflow_o !== eo) || (cp && (fl_if.alloc_preg_o !== ep));
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%0b preg=%0d count=%0d ovf=%0b, expected valid=%0b preg=%0d%s count=%0d ovf=%0b",
                     name, fl_if.alloc_valid_o, fl_if.alloc_preg_o, fl_if.free_count_o,
                     fl_if.overflow_o, ev, ep, cp ? "" : "(unchecked)", ec, eo);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #2;
        check_output({name, "_during"}, 1'b1, 1'b1, 6'd32, 6'd32, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output({name, "_after"}, 1'b1, 1'b1, 6'd32, 6'd32, 1'b0);
    endtask

    initial begin
        int exp_preg;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        fl_if.alloc_req_i       = 1'b0;
        fl_if.release_valid_i   = 2'b00;
        fl_if.release_preg_i[0] = 6'd0;
        fl_if.release_preg_i[1] = 6'd0;

        // Rows start from head=0, tail=1, count=1 with p45 at index 0.
        vecs[0]  = '{"drain_last",     1'b1, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
        vecs[1]  = '{"alloc_on_empty", 1'b1, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0};
        vecs[2]  = '{"rel_p40_port1",  1'b1, 2'b10, 6'd0,  6'd40, 1'b1, 1'b1, 6'd40, 6'd1,  1'b0};
        vecs[3]  = '{"rel_41_42",      1'b0, 2'b11, 6'd41, 6'd42, 1'b1, 1'b1, 6'd40, 6'd3,  1'b0};
        vecs[4]  = '{"rel_43_44",      1'b0, 2'b11, 6'd43, 6'd44, 1'b1, 1'b1, 6'd40, 6'd5,  1'b0};
        vecs[5]  = '{"rel_46_47",      1'b0, 2'b11, 6'd46, 6'd47, 1'b1, 1'b1, 6'd40, 6'd7,  1'b0};
        vecs[6]  = '{"rel_48_49",      1'b0, 2'b11, 6'd48, 6'd49, 1'b1, 1'b1, 6'd40, 6'd9,  1'b0};
        vecs[7]  = '{"rel_52_and_p0",  1'b0, 2'b11, 6'd52, 6'd0,  1'b1, 1'b1, 6'd40, 6'd10, 1'b0};
        vecs[8]  = '{"rel_p0_cnt10",   1'b0, 2'b11, 6'd0,  6'd0,  1'b1, 1'b1, 6'd40, 6'd10, 1'b0};
        vecs[9]  = '{"alloc_40",       1'b1, 2'b00, 6'd0,  6'd0,  1'b1, 1'b1, 6'd41, 6'd9,  1'b0};
        vecs[10] = '{"alloc_rel_53",   1'b1, 2'b10, 6'd0,  6'd53, 1'b1, 1'b1, 6'd42, 6'd9,  1'b0};
        vecs[11] = '{"alloc_rel_p0",   1'b1, 2'b01, 6'd0,  6'd0,  1'b1, 1'b1, 6'd43, 6'd8,  1'b0};

        @(negedge clk);
        do_reset("reset0");

        // Full list: alloc and release p45 together, then drain the other 31.
        apply_stimulus(1'b1, 2'b01, 6'd45, 6'd0);
        check_output("full_alloc_rel45", 1'b1, 1'b1, 6'd33, 6'd32, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            apply_stimulus(1'b1, 2'b00, 6'd0, 6'd0);
            exp_preg = (k <= 30) ? 33 + k : 45;
            check_output($sformatf("drain_%0d", k), 1'b1, 1'b1, 6'(exp_preg), 6'(32 - k), 1'b0);
        end

        for (int v = 0; v < 12; v++) begin
            apply_stimulus(vecs[v].alloc, vecs[v].rel_valid, vecs[v].rel_p0, vecs[v].rel_p1);
            check_output(vecs[v].name, vecs[v].exp_valid, vecs[v].chk_preg,
                         vecs[v].exp_preg, vecs[v].exp_count, vecs[v].exp_ovf);
        end

        // Full list with no allocation: both releases dropped, error is sticky.
        do_reset("reset1");
        apply_stimulus(1'b0, 2'b11, 6'd50, 6'd51);
        check_output("full_drop_50_51", 1'b1, 1'b1, 6'd32, 6'd32, 1'b1);
        apply_stimulus(1'b0, 2'b00, 6'd0, 6'd0);
        check_output("ovf_held", 1'b1, 1'b1, 6'd32, 6'd32, 1'b1);
        apply_stimulus(1'b1, 2'b11, 6'd60, 6'd61);
        check_output("full_alloc_drop_p1", 1'b1, 1'b1, 6'd33, 6'd32, 1'b1);

        // Steady alloc+release stream wraps both pointers (head=1, tail=1, idx0=p60).
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, 2'b01, 6'(i + 1), 6'd0);
            exp_preg = (i <= 29) ? 34 + i : ((i == 30) ? 60 : i - 30);
            check_output($sformatf("stream_%0d", i), 1'b1, 1'b1, 6'(exp_preg), 6'd32, 1'b1);
        end

        #2;
        rst = 1'b1;
        #1;
        check_output("midstream_reset", 1'b1, 1'b1, 6'd32, 6'd32, 1'b0);
        fl_if.alloc_req_i     = 1'b0;
        fl_if.release_valid_i = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // 32 back-to-back allocations from a fresh list.
        for (int k = 1; k <= 32; k++) begin
            apply_stimulus(1'b1, 2'b00, 6'd0, 6'd0);
            check_output($sformatf("alloc_seq_%0d", k), (k < 32), (k < 32),
                         6'(32 + k), 6'(32 - k), 1'b0);
        end
        apply_stimulus(1'b0, 2'b00, 6'd0, 6'd0);
        check_output("empty_idle", 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
